// File: rtl/sig_bundle_byte_tx.sv
// sig_bundle_byte_tx: transmit end of the signal-bundle byte link.
// Takes one {e, f, g[0:2], h[0:2]} bundle per handshake and sends it as a
// framed byte packet. The frame is a header, six payload bytes and an
// optional XOR checksum byte.
//
// Handshake semantics (both sides): a transfer happens on the rising edge
// where valid && ready are both high. Once asserted, valid stays high and
// its payload stays stable until that transfer. Ready may change freely.
// No output depends combinationally on i_sig_vld or i_byte_rdy.
module sig_bundle_byte_tx #(
  parameter logic [3:0] SYNC   = 4'hA,
  parameter bit         CHK_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_sig_vld,
  output logic             o_sig_rdy,
  input  logic             i_sig_e,
  input  logic [1:0]       i_sig_f,
  input  logic [0:2][7:0]  i_sig_g,
  input  logic [7:0]       i_sig_h [0:2],
  output logic             o_byte_vld,
  input  logic             i_byte_rdy,
  output logic [7:0]       o_byte,
  output logic             o_sof,
  output logic             o_eof,
  output logic [15:0]      o_frm_cnt,
  output logic             o_dbg_state
);

  // Index of the final byte in the frame: the checksum byte when enabled.
  localparam logic [2:0] LAST = CHK_EN ? 3'd7 : 3'd6;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic            e_q, e_d;
  logic [1:0]      f_q, f_d;
  logic [0:2][7:0] g_q, g_d;
  logic [0:2][7:0] h_q, h_d;
  logic [15:0]     cnt_q, cnt_d;

  logic [7:0]      hdr;
  logic [7:0]      csum;
  logic [7:0]      byte_sel;

  // Header and checksum come only from the registered bundle, so input
  // changes after acceptance cannot reach the stream.
  assign hdr  = {SYNC, 1'b0, f_q, e_q};
  assign csum = hdr ^ g_q[0] ^ g_q[1] ^ g_q[2] ^ h_q[0] ^ h_q[1] ^ h_q[2];

  // Select the frame byte addressed by the current index.
  always_comb begin
    byte_sel = 8'h00;
    case (idx_q)
      3'd0:    byte_sel = hdr;
      3'd1:    byte_sel = g_q[0];
      3'd2:    byte_sel = g_q[1];
      3'd3:    byte_sel = g_q[2];
      3'd4:    byte_sel = h_q[0];
      3'd5:    byte_sel = h_q[1];
      3'd6:    byte_sel = h_q[2];
      3'd7:    byte_sel = CHK_EN ? csum : 8'h00;
      default: byte_sel = 8'h00;
    endcase
  end

  // Next-state logic: capture in IDLE, walk the byte index in SEND.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    e_d     = e_q;
    f_d     = f_q;
    g_d     = g_q;
    h_d     = h_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (i_sig_vld) begin
          e_d     = i_sig_e;
          f_d     = i_sig_f;
          g_d     = i_sig_g;
          h_d     = {i_sig_h[0], i_sig_h[1], i_sig_h[2]};
          idx_d   = 3'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (i_byte_rdy) begin
          if (idx_q == LAST) begin
            idx_d   = 3'd0;
            cnt_d   = cnt_q + 16'd1;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, index, bundle and frame-counter registers; reset aborts any frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      e_q     <= 1'b0;
      f_q     <= 2'd0;
      g_q     <= '0;
      h_q     <= '0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      e_q     <= e_d;
      f_q     <= f_d;
      g_q     <= g_d;
      h_q     <= h_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are decoded from registered state only.
  assign o_sig_rdy   = (state_q == IDLE);
  assign o_byte_vld  = (state_q == SEND);
  assign o_byte      = (state_q == SEND) ? byte_sel : 8'h00;
  assign o_sof       = (state_q == SEND) && (idx_q == 3'd0);
  assign o_eof       = (state_q == SEND) && (idx_q == LAST);
  assign o_frm_cnt   = cnt_q;
  assign o_dbg_state = state_q;

endmodule
